// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared types and constants for the target game round sequencer.
//   - state_t      : round sequencer states (3-bit encoding)
//   - TIME_W       : width of the seconds countdown
//   - LIFE_W       : width of the per-target lifetime counter
//   - LFSR_W       : width of the pseudo-random generator
//   - IDX_W        : width of a target index (up to 8 targets)
//   - LFSR_TAPS    : feedback mask for x^8 + x^6 + x^5 + x^4 + 1
//   - lfsr_step()  : one Fibonacci shift of the generator
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_ARMED    = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int TIME_W = 6;
    localparam int LIFE_W = 4;
    localparam int LFSR_W = 8;
    localparam int IDX_W  = 3;

    // Bit n-1 of the mask corresponds to polynomial term x^n.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    // Fibonacci form: XOR of the tapped bits is shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAPS);
        return {cur[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// ---------------------------------------------------------------------------
// tick_edge_sync
//   Brings a slow, free-running square wave into the clkIn domain and turns
//   each rising edge into a single-cycle pulse. Usable for any slow clock
//   that is only ever treated as data.
//   The pulse is registered and appears three clkIn cycles after the edge
//   is first sampled.
// Ports
//   clkIn       in  1  system clock
//   reset       in  1  asynchronous active-low reset
//   async_in    in  1  slow asynchronous square wave
//   rise_pulse  out 1  one-cycle pulse per rising edge of async_in
// ---------------------------------------------------------------------------
module tick_edge_sync (
    input  logic clkIn,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic pulse_r;

    // Two-flop synchronizer, one history flop and the registered edge pulse.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            pulse_r <= sync2_r & ~sync3_r;
        end
    end

    assign rise_pulse = pulse_r;

endmodule

// File: rtl/target_scheduler.sv
// ---------------------------------------------------------------------------
// target_scheduler
//   Round sequencer behind game_fsm. While game_active is high it runs the
//   round countdown and lights one target at a time (pseudo-random, never the
//   same target twice in a row), detects the matching button press, and
//   reports player_scored / timer_expired back to game_fsm.
// Parameters
//   NUM_TARGETS      number of targets/buttons (2..8)
//   GAME_TIME        round length in seconds (1..63)
//   TARGET_LIFE      seconds a lit target stays armed (1..15)
//   COOLDOWN_CYCLES  clkIn cycles with all LEDs dark between targets (>=1)
//   LFSR_SEED        non-zero reset value of the random generator
// Ports
//   clkIn          in   1            system clock
//   reset          in   1            asynchronous active-low reset
//   incrementClk   in   1            1 Hz square wave, sampled as data
//   game_active    in   1            high while game_fsm is running a round
//   hit_btn        in   NUM_TARGETS  debounced buttons, level, active-high
//   target_led     out  NUM_TARGETS  one-hot lit target, or all zero
//   player_scored  out  1            one-cycle pulse per correct hit
//   timer_expired  out  1            high from countdown end until game_active falls
//   time_left      out  6            seconds remaining
// ---------------------------------------------------------------------------
module target_scheduler
    import game_pkg::*;
#(
    parameter int                NUM_TARGETS     = 4,
    parameter int                GAME_TIME       = 30,
    parameter int                TARGET_LIFE     = 2,
    parameter int                COOLDOWN_CYCLES = 25_000_000,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = 8'hA5
) (
    input  logic                   clkIn,
    input  logic                   reset,
    input  logic                   incrementClk,
    input  logic                   game_active,
    input  logic [NUM_TARGETS-1:0] hit_btn,
    output logic [NUM_TARGETS-1:0] target_led,
    output logic                   player_scored,
    output logic                   timer_expired,
    output logic [TIME_W-1:0]      time_left
);

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [TIME_W-1:0]      GAME_TIME_V = TIME_W'(GAME_TIME);
    localparam logic [LIFE_W-1:0]      LIFE_V      = LIFE_W'(TARGET_LIFE);
    localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(NUM_TARGETS - 1);
    localparam logic [LFSR_W-1:0]      NUM_T_V     = LFSR_W'(NUM_TARGETS);
    localparam logic [NUM_TARGETS-1:0] ONE_LED     = {{(NUM_TARGETS-1){1'b0}}, 1'b1};
    localparam logic [NUM_TARGETS-1:0] NO_LED      = {NUM_TARGETS{1'b0}};
    // The SPAWN cycle is itself dark, so COOLDOWN is entered with the count
    // already at one: total dark time is COOLDOWN_CYCLES (minimum two).
    localparam logic [CNT_W-1:0]       CNT_ENTRY   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

    // Registered state
    state_t                   state_r;
    logic [NUM_TARGETS-1:0]   target_led_r;
    logic                     player_scored_r;
    logic                     timer_expired_r;
    logic [TIME_W-1:0]        time_left_r;
    logic [LFSR_W-1:0]        lfsr_r;
    logic [IDX_W-1:0]         prev_idx_r;
    logic [LIFE_W-1:0]        life_r;
    logic [CNT_W-1:0]         cool_cnt_r;
    logic [NUM_TARGETS-1:0]   btn_q_r;
    logic [NUM_TARGETS-1:0]   hit_rise_r;

    // Next-state values
    state_t                   state_s;
    logic [NUM_TARGETS-1:0]   target_led_s;
    logic                     player_scored_s;
    logic                     timer_expired_s;
    logic [TIME_W-1:0]        time_left_s;
    logic [IDX_W-1:0]         prev_idx_s;
    logic [LIFE_W-1:0]        life_s;
    logic [CNT_W-1:0]         cool_cnt_s;

    // Decode helpers
    logic                     sec_tick_s;
    logic                     counting_s;
    logic [TIME_W-1:0]        time_dec_s;
    logic                     time_end_s;
    logic [IDX_W-1:0]         raw_idx_s;
    logic [IDX_W-1:0]         spawn_idx_s;
    logic [NUM_TARGETS-1:0]   spawn_led_s;
    logic                     hit_ok_s;

    tick_edge_sync u_sec_tick (
        .clkIn      (clkIn),
        .reset      (reset),
        .async_in   (incrementClk),
        .rise_pulse (sec_tick_s)
    );

    // Per-button rising-edge detection on the debounced levels.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            btn_q_r    <= NO_LED;
            hit_rise_r <= NO_LED;
        end else begin
            btn_q_r    <= hit_btn;
            hit_rise_r <= hit_btn & ~btn_q_r;
        end
    end

    // Countdown decrement and the 1->0 transition that ends the round.
    always_comb begin
        counting_s = (state_r == ST_SPAWN) || (state_r == ST_ARMED) ||
                     (state_r == ST_COOLDOWN);
        if (sec_tick_s && counting_s && (time_left_r != {TIME_W{1'b0}})) begin
            time_dec_s = time_left_r - TIME_W'(1'b1);
            time_end_s = (time_left_r == TIME_W'(1'b1));
        end else begin
            time_dec_s = time_left_r;
            time_end_s = 1'b0;
        end
    end

    // Target choice: LFSR modulo target count, bumped by one on a repeat.
    always_comb begin
        raw_idx_s = IDX_W'(lfsr_r % NUM_T_V);
        if (raw_idx_s == prev_idx_r) begin
            if (raw_idx_s == LAST_IDX) begin
                spawn_idx_s = {IDX_W{1'b0}};
            end else begin
                spawn_idx_s = raw_idx_s + IDX_W'(1'b1);
            end
        end else begin
            spawn_idx_s = raw_idx_s;
        end
        spawn_led_s = ONE_LED << spawn_idx_s;
    end

    // While armed the lit LED is one-hot, so masking the edges selects the
    // matching button without an index lookup.
    assign hit_ok_s = |(hit_rise_r & target_led_r);

    // Sequencer next-state and output decode.
    always_comb begin
        state_s         = state_r;
        target_led_s    = target_led_r;
        player_scored_s = 1'b0;
        timer_expired_s = timer_expired_r;
        time_left_s     = time_dec_s;
        prev_idx_s      = prev_idx_r;
        life_s          = life_r;
        cool_cnt_s      = cool_cnt_r;

        if (!game_active && (state_r != ST_IDLE)) begin
            // Abort: anything pending (including a same-cycle hit) is dropped.
            state_s         = ST_IDLE;
            target_led_s    = NO_LED;
            timer_expired_s = 1'b0;
            time_left_s     = GAME_TIME_V;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    target_led_s    = NO_LED;
                    timer_expired_s = 1'b0;
                    time_left_s     = GAME_TIME_V;
                    if (game_active) begin
                        state_s = ST_SPAWN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_SPAWN: begin
                    if (time_end_s) begin
                        state_s         = ST_DONE;
                        target_led_s    = NO_LED;
                        timer_expired_s = 1'b1;
                    end else begin
                        state_s      = ST_ARMED;
                        target_led_s = spawn_led_s;
                        prev_idx_s   = spawn_idx_s;
                        life_s       = LIFE_V;
                    end
                end

                ST_ARMED: begin
                    // Priority: countdown end, then hit, then life expiry.
                    if (time_end_s) begin
                        state_s         = ST_DONE;
                        target_led_s    = NO_LED;
                        timer_expired_s = 1'b1;
                    end else if (hit_ok_s) begin
                        state_s         = ST_COOLDOWN;
                        target_led_s    = NO_LED;
                        player_scored_s = 1'b1;
                        cool_cnt_s      = CNT_ENTRY;
                    end else if (sec_tick_s) begin
                        if (life_r <= LIFE_W'(1'b1)) begin
                            state_s      = ST_COOLDOWN;
                            target_led_s = NO_LED;
                            cool_cnt_s   = CNT_ENTRY;
                        end else begin
                            life_s = life_r - LIFE_W'(1'b1);
                        end
                    end else begin
                        state_s = ST_ARMED;
                    end
                end

                ST_COOLDOWN: begin
                    target_led_s = NO_LED;
                    if (time_end_s) begin
                        state_s         = ST_DONE;
                        timer_expired_s = 1'b1;
                    end else if (cool_cnt_r >= CNT_LAST) begin
                        state_s = ST_SPAWN;
                    end else begin
                        cool_cnt_s = cool_cnt_r + CNT_W'(1'b1);
                    end
                end

                ST_DONE: begin
                    state_s         = ST_DONE;
                    target_led_s    = NO_LED;
                    timer_expired_s = 1'b1;
                    time_left_s     = {TIME_W{1'b0}};
                end

                default: begin
                    state_s         = ST_IDLE;
                    target_led_s    = NO_LED;
                    timer_expired_s = 1'b0;
                    time_left_s     = GAME_TIME_V;
                end
            endcase
        end
    end

    // Sequencer state, counters, generator and output registers.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            target_led_r    <= NO_LED;
            player_scored_r <= 1'b0;
            timer_expired_r <= 1'b0;
            time_left_r     <= GAME_TIME_V;
            lfsr_r          <= LFSR_SEED;
            prev_idx_r      <= {IDX_W{1'b0}};
            life_r          <= {LIFE_W{1'b0}};
            cool_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r         <= state_s;
            target_led_r    <= target_led_s;
            player_scored_r <= player_scored_s;
            timer_expired_r <= timer_expired_s;
            time_left_r     <= time_left_s;
            lfsr_r          <= lfsr_step(lfsr_r);
            prev_idx_r      <= prev_idx_s;
            life_r          <= life_s;
            cool_cnt_r      <= cool_cnt_s;
        end
    end

    assign target_led    = target_led_r;
    assign player_scored = player_scored_r;
    assign timer_expired = timer_expired_r;
    assign time_left     = time_left_r;

endmodule

// File: tb/tb_target_scheduler.sv
// ---------------------------------------------------------------------------
// tb_target_scheduler
//   Directed bench for target_scheduler with NUM_TARGETS=4, GAME_TIME=5,
//   TARGET_LIFE=2, COOLDOWN_CYCLES=4. Outputs are sampled on the falling
//   clock edge; inputs change right after that edge. Seconds ticks are
//   produced by pulsing incrementClk; the tick takes effect on the fourth
//   rising edge after incrementClk goes high.
// ---------------------------------------------------------------------------
module tb_target_scheduler;

    localparam int NT = 4;
    localparam int GT = 5;
    localparam int TL = 2;
    localparam int CC = 4;

    logic          clkIn = 1'b0;
    logic          reset = 1'b0;
    logic          incrementClk = 1'b0;
    logic          game_active = 1'b0;
    logic [NT-1:0] hit_btn = 4'd0;
    logic [NT-1:0] target_led;
    logic          player_scored;
    logic          timer_expired;
    logic [5:0]    time_left;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic scored_last = 1'b0;

    // Reference generator: x^8+x^6+x^5+x^4+1, seed A5, steps every cycle.
    logic [7:0] model_lfsr;
    logic [7:0] lfsr_cur  = 8'd0;
    logic [7:0] lfsr_prev = 8'd0;
    int         exp_prev  = 0;

    target_scheduler #(
        .NUM_TARGETS     (NT),
        .GAME_TIME       (GT),
        .TARGET_LIFE     (TL),
        .COOLDOWN_CYCLES (CC),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .clkIn         (clkIn),
        .reset         (reset),
        .incrementClk  (incrementClk),
        .game_active   (game_active),
        .hit_btn       (hit_btn),
        .target_led    (target_led),
        .player_scored (player_scored),
        .timer_expired (timer_expired),
        .time_left     (time_left)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn or negedge reset) begin
        if (!reset) model_lfsr <= 8'hA5;
        else        model_lfsr <= {model_lfsr[6:0],
                                   model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, tracking the generator value of each cycle
    // and counting score pulses.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clkIn);
            lfsr_prev = lfsr_cur;
            lfsr_cur  = model_lfsr;
            if (player_scored === 1'b1) begin
                pulses++;
                chk("no_double_pulse", 32'(scored_last), 32'd0);
            end
            scored_last = player_scored;
        end
    endtask

    task automatic wait_lit(input string tag);
        int n;
        n = 0;
        while (target_led == 4'd0 && n < 20) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(target_led != 4'd0), 32'd1);
    endtask

    // Expected LED from the generator value held during the SPAWN cycle.
    task automatic check_spawn(input string tag);
        int         idx;
        logic [3:0] exp_led;
        idx = int'(lfsr_prev) % NT;
        if (idx == exp_prev) idx = (idx + 1) % NT;
        exp_prev = idx;
        exp_led  = 4'd1 << idx;
        chk(tag, 32'(target_led), 32'(exp_led));
    endtask

    task automatic pulse_inc();
        cyc(1);
        incrementClk = 1'b1;
        cyc(4);
        incrementClk = 1'b0;
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] wrong;
        int         p0;
        int         dark;
        int         n;

        // ---- reset values ----
        cyc(3);
        chk("rst_led",     32'(target_led),    32'd0);
        chk("rst_scored",  32'(player_scored), 32'd0);
        chk("rst_expired", 32'(timer_expired), 32'd0);
        chk("rst_time",    32'(time_left),     32'd5);

        // ---- reset in the middle of ARMED ----
        reset = 1'b1;
        game_active = 1'b1;
        wait_lit("spawn0_lit");
        check_spawn("spawn0_idx");
        cyc(2);
        reset = 1'b0;
        game_active = 1'b0;
        #1;
        chk("midrst_led",     32'(target_led),    32'd0);
        chk("midrst_scored",  32'(player_scored), 32'd0);
        chk("midrst_expired", 32'(timer_expired), 32'd0);
        chk("midrst_time",    32'(time_left),     32'd5);
        cyc(2);
        chk("inrst_time", 32'(time_left), 32'd5);
        reset = 1'b1;
        exp_prev = 0;
        cyc(2);
        chk("idle_led",  32'(target_led), 32'd0);
        chk("idle_time", 32'(time_left),  32'd5);

        // ---- correct hit three cycles after the LED lights ----
        game_active = 1'b1;
        wait_lit("spawn1_lit");
        check_spawn("spawn1_idx");
        chk("start_time", 32'(time_left), 32'd5);
        cur = target_led;
        p0  = pulses;
        cyc(3);
        hit_btn = cur;
        cyc(1);
        chk("hit_not_yet", 32'(player_scored), 32'd0);
        cyc(1);
        chk("hit_scored",  32'(player_scored), 32'd1);
        chk("hit_led_off", 32'(target_led),    32'd0);
        hit_btn = 4'd0;
        dark = 1;
        n = 0;
        while (n < 20) begin
            cyc(1);
            n++;
            if (target_led != 4'd0) break;
            dark++;
        end
        chk("dark_cycles", 32'(dark), 32'd4);
        chk("one_pulse", 32'(pulses - p0), 32'd1);
        chk("new_idx_differs", 32'(target_led != cur), 32'd1);
        check_spawn("spawn2_idx");

        // ---- wrong button, then life runs out over two ticks ----
        cur   = target_led;
        wrong = {cur[2:0], cur[3]};
        p0    = pulses;
        hit_btn = wrong;
        cyc(3);
        chk("wrong_btn_ignored", 32'(target_led), 32'(cur));
        hit_btn = 4'd0;
        pulse_inc();
        chk("tick1_time", 32'(time_left),  32'd4);
        chk("tick1_lit",  32'(target_led), 32'(cur));
        pulse_inc();
        chk("tick2_time",    32'(time_left),  32'd3);
        chk("miss_led_off",  32'(target_led), 32'd0);
        chk("miss_no_score", 32'(pulses - p0), 32'd0);
        wait_lit("spawn3_lit");
        check_spawn("spawn3_idx");

        // ---- hit on the same cycle that life reaches zero ----
        pulse_inc();
        chk("tick3_time", 32'(time_left), 32'd2);
        chk("life1_lit",  32'(target_led != 4'd0), 32'd1);
        cur = target_led;
        p0  = pulses;
        cyc(1);
        incrementClk = 1'b1;
        cyc(2);
        hit_btn = cur;
        cyc(2);
        chk("hit_wins_scored", 32'(player_scored), 32'd1);
        chk("hit_wins_led",    32'(target_led),    32'd0);
        chk("tick4_time",      32'(time_left),     32'd1);
        incrementClk = 1'b0;
        hit_btn = 4'd0;
        cyc(1);
        chk("hit_wins_one_pulse", 32'(pulses - p0), 32'd1);
        wait_lit("spawn4_lit");
        check_spawn("spawn4_idx");

        // ---- final tick coincides with a correct hit ----
        cur = target_led;
        p0  = pulses;
        cyc(1);
        incrementClk = 1'b1;
        cyc(2);
        hit_btn = cur;
        cyc(2);
        chk("end_time",    32'(time_left),     32'd0);
        chk("end_expired", 32'(timer_expired), 32'd1);
        chk("end_led",     32'(target_led),    32'd0);
        chk("end_scored",  32'(player_scored), 32'd0);
        incrementClk = 1'b0;
        hit_btn = 4'd0;
        cyc(3);
        chk("done_expired",         32'(timer_expired), 32'd1);
        chk("done_time",            32'(time_left),     32'd0);
        chk("final_hit_not_scored", 32'(pulses - p0),   32'd0);
        game_active = 1'b0;
        cyc(1);
        chk("gameoff_expired", 32'(timer_expired), 32'd0);
        chk("gameoff_time",    32'(time_left),     32'd5);
        chk("gameoff_led",     32'(target_led),    32'd0);

        // ---- abort during COOLDOWN with three seconds left ----
        cyc(2);
        game_active = 1'b1;
        wait_lit("spawn5_lit");
        check_spawn("spawn5_idx");
        pulse_inc();
        chk("g2_tick1_time", 32'(time_left), 32'd4);
        pulse_inc();
        chk("cool_time3", 32'(time_left),  32'd3);
        chk("cool_dark",  32'(target_led), 32'd0);
        game_active = 1'b0;
        cyc(1);
        chk("abort_time",    32'(time_left),     32'd5);
        chk("abort_led",     32'(target_led),    32'd0);
        chk("abort_expired", 32'(timer_expired), 32'd0);
        cyc(4);
        chk("idle_stays_dark", 32'(target_led), 32'd0);
        chk("idle_stays_time", 32'(time_left),  32'd5);
        game_active = 1'b1;
        wait_lit("spawn6_lit");
        check_spawn("spawn6_idx");
        chk("restart_time", 32'(time_left), 32'd5);
        pulse_inc();
        chk("restart_tick_time", 32'(time_left), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
